wb8_mailbox: RTL

WB8_MAILBOX -- requirements
Module: wb8_mailbox

---
 rtl/wb8_mailbox_if.sv | 12 +
 rtl/wb8_mailbox.sv | 76 +++++++
 2 files changed

// File: rtl/wb8_mailbox_if.sv
// wb8_mailbox_if: 8-bit Wishbone classic bus between a master and the mailbox
interface wb8_mailbox_if;
  logic       CYC_I;
  logic       STB_I;
  logic       WE_I;
  logic [1:0] ADR_I;
  logic [7:0] DAT_I;
  logic [7:0] DAT_O;
  logic       ACK_O;
  modport master(output CYC_I, STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
  modport slave(input CYC_I, STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);
endinterface

// File: rtl/wb8_mailbox.sv
// wb8_mailbox: Wishbone byte mailbox with RX/TX FIFOs, sticky overflow flags and irq
module wb8_mailbox #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  wb8_mailbox_if.slave wb,
  input  logic         I_rx_valid,
  input  logic [7:0]   I_rx_data,
  output logic         O_rx_full,
  output logic         O_tx_valid,
  output logic [7:0]   O_tx_data,
  input  logic         I_tx_ready,
  output logic         O_irq
);
  localparam int W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL = W'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2-1:0] P1 = DEPTH_LOG2'(1);
  logic [7:0] rx_mem [1 << DEPTH_LOG2];
  logic [7:0] tx_mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] rx_rp, rx_wp, tx_rp, tx_wp;
  logic [DEPTH_LOG2:0] rx_cnt, tx_cnt;
  logic rx_ovf, tx_ovf, xfer, rd0, wr0, wr1, rx_ne, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0] rdata;
  always_comb begin
    xfer = wb.CYC_I & wb.STB_I;
    rd0 = xfer & ~wb.WE_I & (wb.ADR_I == 2'd0);
    wr0 = xfer & wb.WE_I & (wb.ADR_I == 2'd0);
    wr1 = xfer & wb.WE_I & (wb.ADR_I == 2'd1);
    rx_ne = rx_cnt != '0;
    tx_full = tx_cnt == FULL;
    // fullness/emptiness come from pre-edge counters, so a same-edge pop never frees room
    rx_push = I_rx_valid & ~O_rx_full;
    rx_pop = rd0 & rx_ne;
    tx_push = wr0 & ~tx_full;
    tx_pop = O_tx_valid & I_tx_ready;
    rdata = wb.ADR_I == 2'd0 ? (rx_ne ? rx_mem[rx_rp] : 8'h00) :
            wb.ADR_I == 2'd1 ? {4'b0, tx_ovf, rx_ovf, tx_full, rx_ne} :
            wb.ADR_I == 2'd2 ? 8'(rx_cnt) : 8'(tx_cnt);
  end
  assign O_rx_full = rx_cnt == FULL;
  assign O_tx_valid = tx_cnt != '0;
  assign O_tx_data = tx_mem[tx_rp];
  assign O_irq = rx_ne | rx_ovf | tx_ovf;
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wb.ACK_O <= 1'b0;
      wb.DAT_O <= 8'h00;
      rx_rp <= '0;
      rx_wp <= '0;
      tx_rp <= '0;
      tx_wp <= '0;
      rx_cnt <= '0;
      tx_cnt <= '0;
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      wb.ACK_O <= xfer;
      if (xfer) wb.DAT_O <= wb.WE_I ? 8'h00 : rdata;
      if (rx_push) rx_wp <= rx_wp + P1;
      if (rx_pop) rx_rp <= rx_rp + P1;
      if (tx_push) tx_wp <= tx_wp + P1;
      if (tx_pop) tx_rp <= tx_rp + P1;
      rx_cnt <= rx_cnt + W'(rx_push) - W'(rx_pop);
      tx_cnt <= tx_cnt + W'(tx_push) - W'(tx_pop);
      // a new overflow on the clearing edge keeps the flag set
      rx_ovf <= (I_rx_valid & O_rx_full) | (rx_ovf & ~(wr1 & wb.DAT_I[2]));
      tx_ovf <= (wr0 & tx_full) | (tx_ovf & ~(wr1 & wb.DAT_I[3]));
    end
  end
  always_ff @(posedge CLK_I) begin
    if (rx_push) rx_mem[rx_wp] <= I_rx_data;
    if (tx_push) tx_mem[tx_wp] <= wb.DAT_I;
  end
endmodule
